// File: rtl/max_pool_2x2.sv
// max_pool_2x2
//   Streaming 2x2 / stride-2 max-pooling stage for a packed multi-channel
//   pixel stream that arrives in raster order. Each channel is pooled
//   independently with a signed max, and the output has the same width as
//   the input. A half-width line buffer keeps the horizontal pair maxima of
//   each even row. When the matching pair on the following odd row arrives,
//   the two are combined and the result is registered to the output.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   Data_In    one input pixel; channel k at [k*DATA_WIDHT +: DATA_WIDHT]
//   Valid_In   Data_In carries a pixel this cycle (gaps allowed)
//   Data_Out   pooled pixel, same packing; holds while Valid_Out is low
//   Valid_Out  one-cycle pulse per pooled pixel
//   Frame_Done pulses together with the last pooled pixel of a frame
module max_pool_2x2 #(
   parameter int DATA_WIDHT = 32,
   parameter int IMG_WIDTH  = 44,
   parameter int IMG_HEIGHT = 44,
   parameter int CHANNELS   = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_WIDHT*CHANNELS-1:0] Data_In,
   input  logic                           Valid_In,
   output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
   output logic                           Valid_Out,
   output logic                           Frame_Done
);

   localparam int BUS_W  = DATA_WIDHT * CHANNELS;
   localparam int HALF_W = IMG_WIDTH / 2;
   localparam int HALF_H = IMG_HEIGHT / 2;
   localparam int COL_W  = $clog2(IMG_WIDTH + 1);
   localparam int ROW_W  = $clog2(IMG_HEIGHT + 1);
   localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   // Columns/rows at or beyond these limits are the unpaired trailing
   // column/row of an odd dimension; they are counted but never pooled.
   localparam logic [COL_W-1:0] COL_POOL_END = COL_W'(2 * HALF_W);
   localparam logic [ROW_W-1:0] ROW_POOL_END = ROW_W'(2 * HALF_H);
   localparam logic [COL_W-1:0] COL_FINAL    = COL_W'(2 * HALF_W - 1);
   localparam logic [ROW_W-1:0] ROW_FINAL    = ROW_W'(2 * HALF_H - 1);

   // Per-channel signed maximum; no width growth.
   function automatic logic [BUS_W-1:0] chan_max(input logic [BUS_W-1:0] a,
                                                 input logic [BUS_W-1:0] b);
      logic signed [DATA_WIDHT-1:0] sa;
      logic signed [DATA_WIDHT-1:0] sb;
      logic [BUS_W-1:0]             r;
      r = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         sa = a[k*DATA_WIDHT +: DATA_WIDHT];
         sb = b[k*DATA_WIDHT +: DATA_WIDHT];
         r[k*DATA_WIDHT +: DATA_WIDHT] = (sa > sb) ? sa : sb;
      end
      return r;
   endfunction

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [BUS_W-1:0] hreg;
   logic [BUS_W-1:0] linebuf [0:HALF_W-1];

   logic [LB_AW-1:0] lb_idx;
   logic             col_pool;
   logic             row_pool;
   logic             pair_load;
   logic             lb_write;
   logic             pool_fire;
   logic             last_window;
   logic [BUS_W-1:0] hmax_p0;
   logic [BUS_W-1:0] pooled_p0;

   logic [BUS_W-1:0] data_p1;
   logic             vld_p1;
   logic             done_p1;

   // Raster position counters; they advance only on accepted beats and wrap
   // at the end of the frame so the next beat is pixel (0,0).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col <= '0;
         row <= '0;
      end else if (Valid_In) begin
         if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) row <= '0;
            else                 row <= row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   // ---- stage p0: decode position, horizontal and vertical max ----
   always_comb begin
      lb_idx      = LB_AW'(col >> 1);
      col_pool    = (col < COL_POOL_END);
      row_pool    = (row < ROW_POOL_END);
      pair_load   = Valid_In && !col[0] && col_pool;
      lb_write    = Valid_In &&  col[0] && col_pool && !row[0];
      pool_fire   = Valid_In &&  col[0] && col_pool &&  row[0] && row_pool;
      last_window = (col == COL_FINAL) && (row == ROW_FINAL);
      hmax_p0     = chan_max(hreg, Data_In);
      pooled_p0   = chan_max(hmax_p0, linebuf[lb_idx]);
   end

   // Data-only storage: every entry is written before it is read within a
   // frame, so it needs no reset.
   always_ff @(posedge clk) begin
      if (pair_load) hreg <= Data_In;
      if (lb_write)  linebuf[lb_idx] <= hmax_p0;
   end

   // ---- stage p1: registered pooled output ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_p1 <= '0;
         vld_p1  <= 1'b0;
         done_p1 <= 1'b0;
      end else begin
         vld_p1  <= pool_fire;
         done_p1 <= pool_fire && last_window;
         if (pool_fire) data_p1 <= pooled_p0;
      end
   end

   assign Data_Out   = data_p1;
   assign Valid_Out  = vld_p1;
   assign Frame_Done = done_p1;

endmodule

// File: tb/tb_max_pool_2x2.sv
module tb_max_pool_2x2;
   localparam int DW = 32;
   localparam int CH = 8;
   localparam int BW = DW * CH;

   typedef struct {
      logic [BW-1:0] data;
      logic          done;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [BW-1:0] in4, in2, in5;
   logic          v4, v2, v5;
   logic [BW-1:0] do4, do2, do5;
   logic          vo4, vo2, vo5, fd4, fd2, fd5;

   max_pool_2x2 #(.DATA_WIDHT(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4), .CHANNELS(CH)) u4 (
      .clk(clk), .rst(rst), .Data_In(in4), .Valid_In(v4),
      .Data_Out(do4), .Valid_Out(vo4), .Frame_Done(fd4));
   max_pool_2x2 #(.DATA_WIDHT(DW), .IMG_WIDTH(2), .IMG_HEIGHT(2), .CHANNELS(CH)) u2 (
      .clk(clk), .rst(rst), .Data_In(in2), .Valid_In(v2),
      .Data_Out(do2), .Valid_Out(vo2), .Frame_Done(fd2));
   max_pool_2x2 #(.DATA_WIDHT(DW), .IMG_WIDTH(5), .IMG_HEIGHT(5), .CHANNELS(CH)) u5 (
      .clk(clk), .rst(rst), .Data_In(in5), .Valid_In(v5),
      .Data_Out(do5), .Valid_Out(vo5), .Frame_Done(fd5));

   int            vectors = 0;
   int            miscompares = 0;
   int            sel = 0;
   int            m_w, m_h, m_col, m_row;
   logic [BW-1:0] frame_pix [0:24];
   exp_t          exp_q [$];

   logic [BW-1:0] obs_do;
   logic          obs_vo, obs_fd;
   always_comb begin
      obs_do = do4; obs_vo = vo4; obs_fd = fd4;
      if (sel == 1) begin obs_do = do2; obs_vo = vo2; obs_fd = fd2; end
      if (sel == 2) begin obs_do = do5; obs_vo = vo5; obs_fd = fd5; end
   end

   function automatic logic [BW-1:0] fill(input logic [DW-1:0] v);
      logic [BW-1:0] r;
      for (int k = 0; k < CH; k++) r[k*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [BW-1:0] win_max4(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                              input logic [BW-1:0] c, input logic [BW-1:0] d);
      logic [BW-1:0]        r;
      logic signed [DW-1:0] m;
      for (int k = 0; k < CH; k++) begin
         m = a[k*DW +: DW];
         if ($signed(b[k*DW +: DW]) > m) m = b[k*DW +: DW];
         if ($signed(c[k*DW +: DW]) > m) m = c[k*DW +: DW];
         if ($signed(d[k*DW +: DW]) > m) m = d[k*DW +: DW];
         r[k*DW +: DW] = m;
      end
      return r;
   endfunction

   task automatic select_dut(input int s, input int w, input int h);
      sel = s; m_w = w; m_h = h; m_col = 0; m_row = 0;
      exp_q.delete();
   endtask

   // Drives one beat into the selected DUT, records it in the frame model and
   // queues the expected pooled pixel if this beat completes a window.
   task automatic apply_beat(input logic [BW-1:0] d);
      exp_t e;
      case (sel)
         0: begin in4 = d; v4 = 1'b1; end
         1: begin in2 = d; v2 = 1'b1; end
         default: begin in5 = d; v5 = 1'b1; end
      endcase
      frame_pix[m_row*m_w + m_col] = d;
      if ((m_row % 2 == 1) && (m_col % 2 == 1) &&
          (m_row < 2*(m_h/2)) && (m_col < 2*(m_w/2))) begin
         e.data = win_max4(frame_pix[(m_row-1)*m_w + m_col-1], frame_pix[(m_row-1)*m_w + m_col],
                           frame_pix[m_row*m_w + m_col-1], d);
         e.done = (m_row == 2*(m_h/2)-1) && (m_col == 2*(m_w/2)-1);
         exp_q.push_back(e);
      end
      if (m_col == m_w-1) begin
         m_col = 0;
         m_row = (m_row == m_h-1) ? 0 : m_row + 1;
      end else begin
         m_col = m_col + 1;
      end
      @(posedge clk); #1;
      v4 = 1'b0; v2 = 1'b0; v5 = 1'b0;
   endtask

   task automatic idle_cycle();
      v4 = 1'b0; v2 = 1'b0; v5 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      in4 = '0; in2 = '0; in5 = '0; v4 = 1'b0; v2 = 1'b0; v5 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if ({vo4, vo2, vo5} !== 3'b000) begin miscompares++; $display("FAIL reset_valid got=%b want=000", {vo4, vo2, vo5}); end
      vectors++; if ({fd4, fd2, fd5} !== 3'b000) begin miscompares++; $display("FAIL reset_done got=%b want=000", {fd4, fd2, fd5}); end
      vectors++; if (do4 !== '0) begin miscompares++; $display("FAIL reset_data4 got=%h want=0", do4); end
      vectors++; if (do2 !== '0) begin miscompares++; $display("FAIL reset_data2 got=%h want=0", do2); end
      vectors++; if (do5 !== '0) begin miscompares++; $display("FAIL reset_data5 got=%h want=0", do5); end
      rst = 1'b1;
      idle_cycle();
   endtask

   task automatic test_ramp();
      exp_t        e;
      int          n;
      logic [31:0] ch0_exp [4];
      ch0_exp = '{32'd5, 32'd7, 32'd13, 32'd15};
      n = 0;
      select_dut(0, 4, 4);
      for (int p = 0; p < 16; p++) begin
         apply_beat(fill(32'(p)));
         vectors++; if (obs_vo !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL ramp_valid pix=%0d got=%b want=%b", p, obs_vo, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++; if (obs_do !== e.data) begin miscompares++; $display("FAIL ramp_data pix=%0d got=%h want=%h", p, obs_do, e.data); end
            vectors++; if (obs_do[31:0] !== ch0_exp[n]) begin miscompares++; $display("FAIL ramp_ch0 pix=%0d got=%0d want=%0d", p, obs_do[31:0], ch0_exp[n]); end
            vectors++; if (obs_fd !== e.done) begin miscompares++; $display("FAIL ramp_done pix=%0d got=%b want=%b", p, obs_fd, e.done); end
            n++;
         end else begin
            vectors++; if (obs_fd !== 1'b0) begin miscompares++; $display("FAIL ramp_done_idle pix=%0d got=%b want=0", p, obs_fd); end
         end
      end
      vectors++; if (n != 4) begin miscompares++; $display("FAIL ramp_count got=%0d want=4", n); end
   endtask

   task automatic test_signed();
      exp_t          e;
      logic [31:0]   win [8];
      logic [31:0]   ch0_exp [2];
      logic [BW-1:0] d;
      win = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFE,
              32'h80000000, 32'h00000000, 32'h00000001, 32'h7FFFFFFF};
      ch0_exp = '{32'hFFFFFFFF, 32'h7FFFFFFF};
      select_dut(1, 2, 2);
      for (int i = 0; i < 8; i++) begin
         d = fill(32'(i * 3 + 1));
         d[31:0] = win[i];
         apply_beat(d);
         vectors++; if (obs_vo !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL signed_valid beat=%0d got=%b want=%b", i, obs_vo, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++; if (obs_do !== e.data) begin miscompares++; $display("FAIL signed_data beat=%0d got=%h want=%h", i, obs_do, e.data); end
            vectors++; if (obs_do[31:0] !== ch0_exp[i/4]) begin miscompares++; $display("FAIL signed_ch0 beat=%0d got=%h want=%h", i, obs_do[31:0], ch0_exp[i/4]); end
            vectors++; if (obs_fd !== 1'b1) begin miscompares++; $display("FAIL signed_done beat=%0d got=%b want=1", i, obs_fd); end
         end
      end
   endtask

   task automatic test_channels();
      exp_t          e;
      int            n;
      logic [31:0]   ch1_exp [4];
      logic [BW-1:0] d;
      ch1_exp = '{32'd0, -32'sd2, -32'sd8, -32'sd10};
      n = 0;
      select_dut(0, 4, 4);
      for (int p = 0; p < 16; p++) begin
         d = fill(32'd7);
         d[31:0]  = 32'(p);
         d[63:32] = -32'(p);
         apply_beat(d);
         vectors++; if (obs_vo !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL chan_valid pix=%0d got=%b want=%b", p, obs_vo, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++; if (obs_do !== e.data) begin miscompares++; $display("FAIL chan_data pix=%0d got=%h want=%h", p, obs_do, e.data); end
            vectors++; if (obs_do[63:32] !== ch1_exp[n]) begin miscompares++; $display("FAIL chan_ch1 pix=%0d got=%h want=%h", p, obs_do[63:32], ch1_exp[n]); end
            vectors++; if (obs_do[255:64] !== fill(32'd7) >> 64) begin miscompares++; $display("FAIL chan_rest pix=%0d got=%h", p, obs_do[255:64]); end
            n++;
         end
      end
   endtask

   task automatic test_gapped();
      exp_t          e;
      int            n;
      int            gap;
      logic [BW-1:0] last;
      n = 0;
      last = obs_do;
      select_dut(0, 4, 4);
      for (int p = 0; p < 16; p++) begin
         apply_beat(fill(32'(p)));
         vectors++; if (obs_vo !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL gap_valid pix=%0d got=%b want=%b", p, obs_vo, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++; if (obs_do !== e.data) begin miscompares++; $display("FAIL gap_data pix=%0d got=%h want=%h", p, obs_do, e.data); end
            vectors++; if (obs_fd !== e.done) begin miscompares++; $display("FAIL gap_done pix=%0d got=%b want=%b", p, obs_fd, e.done); end
            last = e.data;
            n++;
         end
         gap = $urandom_range(3, 0);
         for (int g = 0; g < gap; g++) begin
            idle_cycle();
            vectors++; if (obs_vo !== 1'b0) begin miscompares++; $display("FAIL gap_idle_valid pix=%0d got=%b want=0", p, obs_vo); end
            vectors++; if (obs_do !== last) begin miscompares++; $display("FAIL gap_hold pix=%0d got=%h want=%h", p, obs_do, last); end
         end
      end
      vectors++; if (n != 4) begin miscompares++; $display("FAIL gap_count got=%0d want=4", n); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   n;
      n = 0;
      select_dut(0, 4, 4);
      for (int p = 0; p < 6; p++) begin
         apply_beat(fill(32'h7FFFFFFF));
         vectors++; if (obs_vo !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL mid_pre_valid pix=%0d got=%b want=%b", p, obs_vo, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++; if (obs_do !== e.data) begin miscompares++; $display("FAIL mid_pre_data pix=%0d got=%h want=%h", p, obs_do, e.data); end
         end
      end
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         idle_cycle();
         vectors++; if (obs_vo !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid cyc=%0d got=%b want=0", c, obs_vo); end
         vectors++; if (obs_do !== '0) begin miscompares++; $display("FAIL mid_rst_data cyc=%0d got=%h want=0", c, obs_do); end
      end
      rst = 1'b1;
      select_dut(0, 4, 4);
      for (int p = 0; p < 16; p++) begin
         apply_beat(fill(32'(p)));
         vectors++; if (obs_vo !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL mid_valid pix=%0d got=%b want=%b", p, obs_vo, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++; if (obs_do !== e.data) begin miscompares++; $display("FAIL mid_data pix=%0d got=%h want=%h", p, obs_do, e.data); end
            vectors++; if (obs_fd !== e.done) begin miscompares++; $display("FAIL mid_done pix=%0d got=%b want=%b", p, obs_fd, e.done); end
            n++;
         end
      end
      vectors++; if (n != 4) begin miscompares++; $display("FAIL mid_count got=%0d want=4", n); end
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      int          n;
      logic [31:0] ch0_exp [4];
      ch0_exp = '{32'd6, 32'd8, 32'd16, 32'd18};
      select_dut(2, 5, 5);
      for (int f = 0; f < 2; f++) begin
         n = 0;
         for (int p = 0; p < 25; p++) begin
            apply_beat(fill(32'(p)));
            vectors++; if (obs_vo !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL b2b_valid f=%0d pix=%0d got=%b want=%b", f, p, obs_vo, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               vectors++; if (obs_do !== e.data) begin miscompares++; $display("FAIL b2b_data f=%0d pix=%0d got=%h want=%h", f, p, obs_do, e.data); end
               vectors++; if (obs_do[31:0] !== ch0_exp[n]) begin miscompares++; $display("FAIL b2b_ch0 f=%0d pix=%0d got=%0d want=%0d", f, p, obs_do[31:0], ch0_exp[n]); end
               vectors++; if (obs_fd !== e.done) begin miscompares++; $display("FAIL b2b_done f=%0d pix=%0d got=%b want=%b", f, p, obs_fd, e.done); end
               n++;
            end else begin
               vectors++; if (obs_fd !== 1'b0) begin miscompares++; $display("FAIL b2b_done_idle f=%0d pix=%0d got=%b want=0", f, p, obs_fd); end
            end
         end
         vectors++; if (n != 4) begin miscompares++; $display("FAIL b2b_count f=%0d got=%0d want=4", f, n); end
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_signed();
      test_channels();
      test_gapped();
      test_reset_mid();
      test_back_to_back();
      idle_cycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
